mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage data-memory access unit. Sits directly downstream of the E→M pipeline register and consumes its M-stage outputs: address, store data, access size and load-sign control. It runs a request/grant/response handshake on the data-memory port and stalls the pipeline until each access completes. It returns sign- or zero-extended load data to the M→W path and flags misaligned accesses and response timeouts.

## Interface
Parameters:
- TIMEOUT, 16, maximum cycles to wait for `dmem_rvalid` after a load grant before the access is aborted.

Ports:
- `clk` in 1: the block's single clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `MemReadM` in 1: load in M stage.
- `MemWriteM` in 1: store in M stage.
- `s_selM` in 2: store size; 00 byte, 01 half, 10 word.
- `l_selM` in 2: load size; 00 byte, 01 half, 10 word.
- `u_loadM` in 1: 1 zero-extends the load, 0 sign-extends it.
- `ALUResultM` in 32: byte address.
- `WriteDataM` in 32: store data, right-justified.
- `ReadDataM` out 32: extended load data.
- `StallM` out 1: holds the F/D/E/M pipeline registers.
- `MisalignM` out 1: misaligned-access pulse.
- `BusErrM` out 1: timeout pulse.
- `dmem_req` out 1: bus request.
- `dmem_we` out 1: 1 = write.
- `dmem_addr` out 32: `{ALUResultM[31:2],2'b00}`.
- `dmem_be` out 4: byte enables.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_gnt` in 1: request accepted.
- `dmem_rvalid` in 1: read data valid.
- `dmem_rdata` in 32: read word.

## Operation
- Op valid = `MemReadM | MemWriteM`. Both high at once is illegal; `MemReadM` wins.
- Misaligned: half with `addr[0]=1`, or word with `addr[1:0]!=0`. A reserved size code (11) counts as misaligned.
  - No bus request is issued, and the store is suppressed.
  - `ReadDataM=0`, `MisalignM=1`, `StallM=0`, for the single M cycle.
- Store lanes:
  - byte: `be = 4'b0001<<addr[1:0]`, `wdata = {4{WriteDataM[7:0]}}`.
  - half: `be = 4'b0011<<{addr[1],1'b0}`, `wdata = {2{WriteDataM[15:0]}}`.
  - word: `be = 4'hF`, `wdata = WriteDataM`.
- Load extension: select the lane from `dmem_rdata` using `addr[1:0]` and `l_selM`, then extend per `u_loadM`. For loads, `dmem_be` carries the load lanes.
- FSM states: IDLE, WAIT_GNT, WAIT_RVALID.
  - IDLE, with a valid aligned op:
    - `dmem_req=1`.
    - On `gnt`: a store completes (stay in IDLE); a load moves to WAIT_RVALID.
    - With no `gnt`: move to WAIT_GNT.
  - WAIT_GNT:
    - `dmem_req=1`.
    - On `gnt`: a store moves to IDLE; a load moves to WAIT_RVALID.
  - WAIT_RVALID:
    - `dmem_req=0`, and the wait counter increments every cycle.
    - On `rvalid`: drive `ReadDataM` = extended `rdata`; the load completes; move to IDLE.
    - When the counter reaches TIMEOUT-1 with no `rvalid`: `BusErrM=1`, `ReadDataM=0`, the load completes, move to IDLE.
- `StallM = op & aligned & !complete_this_cycle`, evaluated in every state.
- `ReadDataM` is 0 whenever no load completes in the cycle.
- `dmem_rvalid` is ignored in IDLE and WAIT_GNT. `dmem_gnt` is ignored in WAIT_RVALID.
- M-stage inputs are stable while `StallM=1`, because the pipeline is held.

## Timing
- Reset (`rst_n=0` at a `clk` edge):
  - state goes to IDLE and the counter goes to 0.
  - all outputs are 0 in the reset cycle; combinational outputs are also forced to 0 while `rst_n=0`.
  - a request or response outstanding across reset is abandoned, and a late `rvalid` is ignored.
- Store with `gnt` in the same cycle: 0 stall cycles.
- Store with `gnt` after N cycles: N stall cycles.
- Load with `gnt` at cycle 0 and `rvalid` at cycle k≥1: `StallM` is high for cycles 0..k-1 and low at k. `ReadDataM` is valid at cycle k and is captured by the M→W register at the end of k.
- Timeout: `BusErrM` asserts on WAIT_RVALID cycle TIMEOUT; no more than TIMEOUT stall cycles follow the grant.
- Back-to-back ops: the next op can request in the cycle after completion, so one op is accepted per cycle at best.
- Counter: `$clog2(TIMEOUT)` bits, cleared on entry to WAIT_RVALID, with no wrap past TIMEOUT-1.

## Structure
- Shared package `mem_pkg`:
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`.
  - state enum `mem_state_t`.
  - functions for the byte-enable mask and the misalignment check.
- Sub-module `load_extend`: combinational lane select plus sign/zero extension, taking `rdata`, `addr[1:0]`, `l_sel` and `u_load`.

## Test plan
- Store byte: `addr=0x1003`, `WriteDataM=0x000000A5`, `gnt` same cycle → `be=1000`, `wdata=0xA5A5A5A5`, `addr=0x1000`, `StallM` never high.
- Load half signed: `addr=0x2002`, `rdata=0x8001_1234`, `gnt` at cycle 0, `rvalid` at cycle 3 → `StallM` high for 3 cycles, then `ReadDataM=0xFFFF8001`. Repeat with `u_loadM=1` → `0x00008001`.
- Misaligned word load: `addr=0x3001` → `dmem_req` stays 0, `MisalignM=1`, `StallM=0`, `ReadDataM=0`.
- Grant backpressure: store with `gnt` held low 4 cycles → `dmem_req` high 5 cycles, `StallM` high 4 cycles, the store is issued exactly once.
- Timeout: TIMEOUT=16, load granted, `rvalid` never arrives → `BusErrM` on the 16th wait cycle, `ReadDataM=0`, FSM back in IDLE; a stale `rvalid` two cycles later is ignored.
- Reset mid-load: `rst_n=0` while in WAIT_RVALID → next cycle IDLE with all outputs 0; a following word load from `0x4000` completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory-stage data-memory access unit:
//   - access size encodings (byte / half / word, 11 reserved)
//   - FSM state type for the bus handshake
//   - helpers for the byte-enable mask, the misalignment test and
//     store-data lane replication
// ----------------------------------------------------------------------------
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'b00,
        ST_WAIT_GNT    = 2'b01,
        ST_WAIT_RVALID = 2'b10
    } mem_state_t;

    // Byte lanes touched by an access of the given size at the given offset.
    function automatic logic [3:0] be_mask(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic [3:0] mask;
        case (size)
            SZ_BYTE: mask = 4'b0001 << addr_lo;
            SZ_HALF: mask = 4'b0011 << {addr_lo[1], 1'b0};
            SZ_WORD: mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // The reserved size code is treated as misaligned so it never reaches the bus.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = (addr_lo != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

    // Copy the right-justified store data into every lane it could land in,
    // so the byte enables alone select the target bytes.
    function automatic logic [31:0] lane_replicate(input logic [1:0]  size,
                                                   input logic [31:0] data);
        logic [31:0] rep;
        case (size)
            SZ_BYTE: rep = {4{data[7:0]}};
            SZ_HALF: rep = {2{data[15:0]}};
            SZ_WORD: rep = data;
            default: rep = 32'h0000_0000;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/load_extend.sv
// ----------------------------------------------------------------------------
// load_extend
// Combinational load-lane select and sign/zero extension.
// Ports:
//   rdata_i   [31:0] : raw word returned by data memory
//   addr_lo_i [1:0]  : byte offset of the load
//   l_sel_i   [1:0]  : load size (byte / half / word)
//   u_load_i         : 1 = zero-extend, 0 = sign-extend
//   data_o    [31:0] : extended load result (0 for the reserved size)
// ----------------------------------------------------------------------------
module load_extend (
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  l_sel_i,
    input  logic        u_load_i,
    output logic [31:0] data_o
);
    import mem_pkg::*;

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic        bsign_s;
    logic        hsign_s;

    // Pick the addressed byte/half lane and extend it to 32 bits.
    always_comb begin
        case (addr_lo_i)
            2'b00:   byte_s = rdata_i[7:0];
            2'b01:   byte_s = rdata_i[15:8];
            2'b10:   byte_s = rdata_i[23:16];
            2'b11:   byte_s = rdata_i[31:24];
            default: byte_s = 8'h00;
        endcase
        half_s  = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        bsign_s = ~u_load_i & byte_s[7];
        hsign_s = ~u_load_i & half_s[15];
        case (l_sel_i)
            SZ_BYTE: data_o = {{24{bsign_s}}, byte_s};
            SZ_HALF: data_o = {{16{hsign_s}}, half_s};
            SZ_WORD: data_o = rdata_i;
            default: data_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
// Memory-stage data-memory access unit. Issues a request/grant/response
// transaction for each aligned load or store held in the M stage, stalls the
// pipeline until it completes, returns extended load data, and flags
// misaligned accesses and load-response timeouts.
// Parameter:
//   TIMEOUT : cycles to wait for dmem_rvalid after a load grant
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   MemReadM / MemWriteM       : load / store in M (load wins if both)
//   s_selM / l_selM            : store / load size
//   u_loadM                    : zero-extend (1) or sign-extend (0) loads
//   ALUResultM / WriteDataM    : byte address / right-justified store data
//   ReadDataM                  : extended load data, 0 unless a load completes
//   StallM                     : hold F/D/E/M while an access is in flight
//   MisalignM / BusErrM        : misaligned-access / timeout pulses
//   dmem_req/we/addr/be/wdata  : data-memory request side
//   dmem_gnt/rvalid/rdata      : data-memory grant and response side
// Outputs are combinational so a same-cycle grant or response completes the
// access without a stall; all of them are forced to 0 while rst_n is low.
// ----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [1:0]  s_selM,
    input  logic [1:0]  l_selM,
    input  logic        u_loadM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);
    import mem_pkg::*;

    localparam int             CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    mem_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        op_s;
    logic [1:0]  size_s;
    logic [1:0]  addr_lo_s;
    logic        misalign_s;
    logic        go_s;
    logic        req_s;
    logic        done_s;
    logic        ld_done_s;
    logic        tmo_s;
    logic [31:0] ext_s;

    assign op_s       = MemReadM | MemWriteM;
    assign size_s     = MemReadM ? l_selM : s_selM;
    assign addr_lo_s  = ALUResultM[1:0];
    assign misalign_s = is_misaligned(size_s, addr_lo_s);
    assign go_s       = op_s & ~misalign_s;

    load_extend u_load_extend (
        .rdata_i   (dmem_rdata),
        .addr_lo_i (addr_lo_s),
        .l_sel_i   (l_selM),
        .u_load_i  (u_loadM),
        .data_o    (ext_s)
    );

    // Handshake FSM: next state, wait counter, request and completion strobes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_s     = 1'b0;
        done_s    = 1'b0;
        ld_done_s = 1'b0;
        tmo_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (go_s) begin
                    req_s = 1'b1;
                    if (dmem_gnt) begin
                        if (MemReadM) begin
                            state_d = ST_WAIT_RVALID;
                        end else begin
                            done_s  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_WAIT_GNT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_GNT: begin
                cnt_d = '0;
                req_s = 1'b1;
                if (dmem_gnt) begin
                    if (MemReadM) begin
                        state_d = ST_WAIT_RVALID;
                    end else begin
                        done_s  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_WAIT_GNT;
                end
            end
            ST_WAIT_RVALID: begin
                if (dmem_rvalid) begin
                    done_s    = 1'b1;
                    ld_done_s = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    // Abort: the access completes with a bus error and no data.
                    done_s  = 1'b1;
                    tmo_s   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = ST_WAIT_RVALID;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and wait-counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output decode; everything is held at 0 while reset is asserted.
    always_comb begin
        ReadDataM  = 32'h0000_0000;
        StallM     = 1'b0;
        MisalignM  = 1'b0;
        BusErrM    = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = 32'h0000_0000;
        dmem_be    = 4'b0000;
        dmem_wdata = 32'h0000_0000;
        if (rst_n) begin
            StallM    = go_s & ~done_s;
            // Inputs are held during a stall, so a misaligned op is only seen in IDLE.
            MisalignM = (state_q == ST_IDLE) & op_s & misalign_s;
            BusErrM   = tmo_s;
            dmem_req  = req_s;
            ReadDataM = ld_done_s ? ext_s : 32'h0000_0000;
            if (go_s) begin
                dmem_we    = ~MemReadM;
                dmem_addr  = {ALUResultM[31:2], 2'b00};
                dmem_be    = be_mask(size_s, addr_lo_s);
                dmem_wdata = MemReadM ? 32'h0000_0000 : lane_replicate(s_selM, WriteDataM);
            end else begin
                dmem_we    = 1'b0;
                dmem_addr  = 32'h0000_0000;
                dmem_be    = 4'b0000;
                dmem_wdata = 32'h0000_0000;
            end
        end else begin
            StallM   = 1'b0;
            dmem_req = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemReadM, MemWriteM;
    logic [1:0]  s_selM, l_selM;
    logic        u_loadM;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM, MisalignM, BusErrM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .MemReadM    (MemReadM),
        .MemWriteM   (MemWriteM),
        .s_selM      (s_selM),
        .l_selM      (l_selM),
        .u_loadM     (u_loadM),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .ReadDataM   (ReadDataM),
        .StallM      (StallM),
        .MisalignM   (MisalignM),
        .BusErrM     (BusErrM),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    bus_t  bus_q[$];
    resp_t load_q[$];
    int    mis_pending = 0;
    int    n_checks = 0;
    int    n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic bit m_misaligned(input int size, input int a);
        return (size == 3) || (size == 1 && (a % 2) != 0) || (size == 2 && a != 0);
    endfunction

    function automatic logic [3:0] m_be(input int size, input int a);
        int m;
        if (size == 0)      m = 1 << a;
        else if (size == 1) m = 3 << (2 * (a / 2));
        else                m = 15;
        return 4'(m);
    endfunction

    function automatic logic [31:0] m_wdata(input int size, input logic [31:0] d);
        if (size == 0)      return (d & 32'h0000_00FF) * 32'h0101_0101;
        else if (size == 1) return (d & 32'h0000_FFFF) * 32'h0001_0001;
        else                return d;
    endfunction

    function automatic logic [31:0] m_load(input int size, input int a, input bit u, input logic [31:0] w);
        longint v;
        if (size == 0) begin
            v = longint'((w >> (8 * a)) & 32'h0000_00FF);
            if (!u && v >= 128) v = v - 256;
        end else if (size == 1) begin
            v = longint'((w >> (16 * (a / 2))) & 32'h0000_FFFF);
            if (!u && v >= 32768) v = v - 65536;
        end else begin
            v = longint'(w);
        end
        return v[31:0];
    endfunction

    function automatic logic all_out();
        return |{ReadDataM, StallM, MisalignM, BusErrM, dmem_req, dmem_we,
                 dmem_addr, dmem_be, dmem_wdata};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        bus_t  bt;
        resp_t rt;
        if (rst_n === 1'b1) begin
            if (dmem_req && dmem_gnt) begin
                if (bus_q.size() == 0) begin
                    check("unexpected_bus_txn", 32'(dmem_addr), 32'hFFFF_FFFF);
                end else begin
                    bt = bus_q.pop_front();
                    check("bus_we", 32'(dmem_we), 32'(bt.we));
                    check("bus_addr", dmem_addr, bt.addr);
                    check("bus_be", 32'(dmem_be), 32'(bt.be));
                    if (bt.we) check("bus_wdata", dmem_wdata, bt.wdata);
                end
            end
            if (MisalignM) begin
                check("misalign_expected", 32'(mis_pending > 0), 32'd1);
                if (mis_pending > 0) mis_pending--;
                check("misalign_quiet", 32'({dmem_req, StallM, |ReadDataM}), 32'd0);
            end
            if (MemReadM && !StallM && !MisalignM) begin
                if (load_q.size() == 0) begin
                    check("unexpected_load_done", ReadDataM, 32'hFFFF_FFFF);
                end else begin
                    rt = load_q.pop_front();
                    check("load_data", ReadDataM, rt.data);
                    check("load_buserr", 32'(BusErrM), 32'(rt.err));
                end
            end else begin
                check("idle_rdata_buserr", 32'({|ReadDataM, BusErrM}), 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_idle(input bit rv);
        MemReadM    = 1'b0;
        MemWriteM   = 1'b0;
        dmem_gnt    = 1'($urandom_range(0, 1));
        dmem_rvalid = rv;
        dmem_rdata  = $urandom();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // k_rv = 0 means the load response never arrives.
    task automatic run_op(input bit rd, input bit wr, input logic [1:0] ssel,
                          input logic [1:0] lsel, input bit u, input logic [31:0] addr,
                          input logic [31:0] wd, input int n_gnt, input int k_rv,
                          input logic [31:0] rword, input string tag);
        int    size, a, total, exp_stall, exp_req, rv_cyc;
        int    stall_cnt, req_cnt;
        bit    mis;
        bus_t  bt;
        resp_t rt;
        size      = rd ? int'(lsel) : int'(ssel);
        a         = int'(addr[1:0]);
        mis       = m_misaligned(size, a);
        rv_cyc    = -1;
        stall_cnt = 0;
        req_cnt   = 0;
        if (mis) begin
            total = 1; exp_stall = 0; exp_req = 0;
            mis_pending++;
        end else begin
            bt.we    = !rd;
            bt.addr  = addr & ~32'h3;
            bt.be    = m_be(size, a);
            bt.wdata = m_wdata(size, wd);
            bus_q.push_back(bt);
            exp_req = n_gnt + 1;
            if (!rd) begin
                total = n_gnt + 1; exp_stall = n_gnt;
            end else if (k_rv > 0) begin
                rv_cyc = n_gnt + k_rv; total = rv_cyc + 1; exp_stall = rv_cyc;
                rt.data = m_load(size, a, u, rword); rt.err = 1'b0;
                load_q.push_back(rt);
            end else begin
                total = n_gnt + TIMEOUT + 1; exp_stall = n_gnt + TIMEOUT;
                rt.data = 32'h0; rt.err = 1'b1;
                load_q.push_back(rt);
            end
        end
        for (int c = 0; c < total; c++) begin
            MemReadM   = rd;
            MemWriteM  = wr;
            s_selM     = ssel;
            l_selM     = lsel;
            u_loadM    = u;
            ALUResultM = addr;
            WriteDataM = wd;
            if (mis)                  dmem_gnt = 1'($urandom_range(0, 1));
            else if (c == n_gnt)      dmem_gnt = 1'b1;
            else if (rd && c > n_gnt) dmem_gnt = 1'($urandom_range(0, 1));
            else                      dmem_gnt = 1'b0;
            if (c == rv_cyc)      dmem_rvalid = 1'b1;
            else if (c <= n_gnt)  dmem_rvalid = 1'($urandom_range(0, 1));
            else                  dmem_rvalid = 1'b0;
            dmem_rdata = (c == rv_cyc) ? rword : $urandom();
            @(negedge clk);
            if (StallM)   stall_cnt++;
            if (dmem_req) req_cnt++;
            @(posedge clk);
            #1;
        end
        check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
        check({tag, "_req_cycles"}, 32'(req_cnt), 32'(exp_req));
    endtask

    initial begin
        bus_t bt;
        int   kind, ng, kr;
        logic [31:0] ad;

        // Reset with an active-looking op on the inputs: every output must stay 0.
        rst_n = 1'b0;
        MemReadM = 1'b1; MemWriteM = 1'b0; s_selM = 2'b10; l_selM = 2'b10; u_loadM = 1'b0;
        ALUResultM = 32'h0000_0010; WriteDataM = 32'h1234_5678;
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        repeat (2) begin
            @(negedge clk);
            check("reset_outputs", 32'(all_out()), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_idle(1'b0);

        // Directed cases.
        run_op(1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'h0, "store_byte");
        run_op(1'b1, 1'b0, 2'b00, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 0, 3, 32'h8001_1234, "load_half_s");
        run_op(1'b1, 1'b0, 2'b00, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 0, 3, 32'h8001_1234, "load_half_u");
        run_op(1'b1, 1'b0, 2'b00, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 0, 1, 32'h0, "misalign_word");
        run_op(1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 32'h0000_5004, 32'hCAFE_F00D, 4, 0, 32'h0, "store_backpressure");
        run_op(1'b1, 1'b0, 2'b00, 2'b10, 1'b0, 32'h0000_6000, 32'h0, 0, 0, 32'h0, "load_timeout");
        run_idle(1'b0);
        run_idle(1'b1);

        // Reset while waiting for a load response.
        bt.we = 1'b0; bt.addr = 32'h0000_2000; bt.be = 4'hF; bt.wdata = 32'h0;
        bus_q.push_back(bt);
        MemReadM = 1'b1; MemWriteM = 1'b0; l_selM = 2'b10; u_loadM = 1'b0;
        ALUResultM = 32'h0000_2000; dmem_gnt = 1'b1; dmem_rvalid = 1'b0;
        @(negedge clk); @(posedge clk); #1;
        dmem_gnt = 1'b0;
        repeat (2) begin @(negedge clk); @(posedge clk); #1; end
        rst_n = 1'b0;
        @(negedge clk);
        check("midload_reset_outputs", 32'(all_out()), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; MemReadM = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("post_reset_idle", 32'(all_out()), 32'd0);
        @(posedge clk); #1;
        run_op(1'b1, 1'b0, 2'b00, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 0, 2, 32'h1357_9BDF, "load_after_reset");

        // Randomized traffic, including reserved sizes and back-to-back ops.
        for (int i = 0; i < 150; i++) begin
            kind = int'($urandom_range(0, 9));
            ad   = $urandom();
            if ($urandom_range(0, 1) == 1) ad[1:0] = 2'b00;
            ng = int'($urandom_range(0, 3));
            kr = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 4));
            if (kind == 0)
                run_idle(1'($urandom_range(0, 1)));
            else
                run_op((kind >= 5), (kind <= 4) || (kind == 9),
                       2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), ad, $urandom(), ng, kr, $urandom(), "rand");
        end
        run_idle(1'b0);

        check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        check("load_queue_drained", 32'(load_q.size()), 32'd0);
        check("misalign_all_seen", 32'(mis_pending), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
